// File: rtl/dm_sync.sv
// dm_sync: clocked request/response data memory with wait states and error reporting.
// Build macro DM_BYTE_WRITE_EN enables per-byte write masking through DMBE.
//
// state  | meaning
// IDLE   | ready, no access in flight
// WAIT   | access captured, counting down wait states
// RESP   | response valid this cycle, ready for the next request
module dm_sync #(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 64,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                DMREQ,
  input  logic                DMWE,
  input  logic [DATA_W/8-1:0] DMBE,
  input  logic [31:0]         DMA,
  input  logic [DATA_W-1:0]   DMWD,
  output logic                DMRDY,
  output logic                DMVALID,
  output logic [DATA_W-1:0]   DMRD,
  output logic                DMERR
);

  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [NB-1:0]     be_q, be_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              err_q, err_d;

  logic              rdy;
  logic              accept;
  logic              commit;
  logic              mem_we;
  logic [31:0]       src_a;
  logic              src_we;
  logic [NB-1:0]     src_be;
  logic [DATA_W-1:0] src_wd;
  logic [NB-1:0]     be_eff;
  logic [AW-1:0]     idx;
  logic              src_err;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] merged;
  logic              unused_be;

  assign rdy    = (state_q != S_WAIT) & ~RST;
  assign accept = DMREQ & rdy;

  // With wait states the access comes from the capture registers; with none it
  // commits straight from the port on the accepting edge.
  always_comb begin
    if (state_q == S_WAIT) begin
      src_a  = addr_q;
      src_we = we_q;
      src_be = be_q;
      src_wd = wd_q;
    end else begin
      src_a  = DMA;
      src_we = DMWE;
      src_be = DMBE;
      src_wd = DMWD;
    end
  end

`ifdef DM_BYTE_WRITE_EN
  assign be_eff    = src_be;
  assign unused_be = 1'b0;
`else
  assign be_eff    = '1;
  assign unused_be = ^src_be;
`endif

  assign idx     = src_a[AW+1:2];
  assign src_err = (|src_a[1:0]) | (|src_a[31:AW+2]);
  assign cur     = mem[idx];

  always_comb begin
    merged = cur;
    for (int i = 0; i < NB; i++) begin
      if (be_eff[i]) merged[8*i +: 8] = src_wd[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          addr_d = DMA;
          we_d   = DMWE;
          be_d   = DMBE;
          wd_d   = DMWD;
          if (LATENCY == 0) begin
            state_d = S_RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_CNT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign commit = (state_d == S_RESP) & ~RST;
  assign mem_we = commit & src_we & ~src_err;

  always_comb begin
    rd_d  = rd_q;
    err_d = err_q;
    if (commit) begin
      err_d = src_err;
      if (src_err)     rd_d = '0;
      else if (src_we) rd_d = merged;
      else             rd_d = cur;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[idx] <= merged;
  end

  assign DMRDY   = rdy;
  assign DMVALID = (state_q == S_RESP);
  assign DMRD    = rd_q;
  assign DMERR   = err_q & (state_q == S_RESP);

endmodule

// File: tb/tb_dm_sync.sv
// Bench for dm_sync: four instances with LATENCY 0..3 sharing one clock,
// table-driven vectors plus directed sequences checked through a response scoreboard.
module tb_dm_sync;

`ifdef DM_BYTE_WRITE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic        clk;
  logic        rst   [4];
  logic        req   [4];
  logic        dwe;
  logic [3:0]  dbe;
  logic [31:0] da;
  logic [31:0] dwd;
  logic        rdy   [4];
  logic        valid [4];
  logic [31:0] rd    [4];
  logic        err   [4];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      dm_sync #(.DATA_W(32), .DEPTH(64), .LATENCY(g), .INIT_FILE("")) u_dut (
        .CLK(clk), .RST(rst[g]), .DMREQ(req[g]), .DMWE(dwe), .DMBE(dbe),
        .DMA(da), .DMWD(dwd), .DMRDY(rdy[g]), .DMVALID(valid[g]),
        .DMRD(rd[g]), .DMERR(err[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          inst;
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (valid[k] === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: inst %0d got rd=%h with nothing expected", k, rd[k]);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_inst", k, mon_e.inst);
          chk("resp_rd", rd[k], mon_e.rd);
          chk("resp_err", {31'd0, err[k]}, {31'd0, mon_e.err});
          chk("resp_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic issue(input int k, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] erd, input logic eerr,
                       input bit push, output int lowc);
    int n;
    lowc = 0;
    @(negedge clk);
    req[k] = 1'b1;
    dwe = we; da = a; dwd = wd; dbe = be;
    n = 0;
    while (rdy[k] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
      lowc++;
    end
    if (rdy[k] !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: inst %0d ready=%b expected 1", k, rdy[k]);
    end else if (push) begin
      sb.push_back('{k, erd, eerr, cyc + 1 + k});
    end
    @(posedge clk);
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    req[k] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  int lowc;
  logic [31:0] byte_exp, byte_exp2;

  initial begin
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1;
      req[k] = 1'b0;
    end
    dwe = 1'b0; dbe = 4'h0; da = 32'd0; dwd = 32'd0;

    byte_exp  = BYTE_EN ? 32'hDEADBE55 : 32'h00000055;
    byte_exp2 = BYTE_EN ? 32'hCAABF00D : 32'h00AB0000;
    vt[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0};
    vt[1]  = '{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h10,       32'h00000055, 4'h1, byte_exp,     1'b0};
    vt[3]  = '{1'b0, 32'h10,       32'h0,        4'h0, byte_exp,     1'b0};
    vt[4]  = '{1'b0, 32'h13,       32'h0,        4'h0, 32'h0,        1'b1};
    vt[5]  = '{1'b0, 32'h100,      32'h0,        4'h0, 32'h0,        1'b1};
    vt[6]  = '{1'b1, 32'h12,       32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vt[7]  = '{1'b1, 32'h110,      32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vt[8]  = '{1'b0, 32'h10,       32'h0,        4'h0, byte_exp,     1'b0};
    vt[9]  = '{1'b1, 32'hFC,       32'h11223344, 4'hF, 32'h11223344, 1'b0};
    vt[10] = '{1'b0, 32'hFC,       32'h0,        4'h0, 32'h11223344, 1'b0};
    vt[11] = '{1'b1, 32'h4,        32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 1'b0};
    vt[12] = '{1'b1, 32'h4,        32'h00AB0000, 4'h4, byte_exp2,    1'b0};
    vt[13] = '{1'b0, 32'h80000004, 32'h0,        4'h0, 32'h0,        1'b1};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("reset_rdy", {31'd0, rdy[k]}, 32'd0);
      chk("reset_valid", {31'd0, valid[k]}, 32'd0);
      chk("reset_rd", rd[k], 32'd0);
      chk("reset_err", {31'd0, err[k]}, 32'd0);
    end
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) chk("release_rdy", {31'd0, rdy[k]}, 32'd1);

    // LATENCY=1 vector table, issued back to back
    for (int i = 0; i < 14; i++)
      issue(1, vt[i].we, vt[i].a, vt[i].wd, vt[i].be, vt[i].rd, vt[i].err, 1'b1, lowc);
    idle(1);
    issue(1, 1'b0, 32'h4, 32'h0, 4'h0, byte_exp2, 1'b0, 1'b1, lowc);
    idle(1);
    drain();

    // LATENCY=0: one response per cycle, read in RESP of a write sees new data
    issue(0, 1'b1, 32'h0, 32'h1,        4'hF, 32'h1,        1'b0, 1'b1, lowc);
    issue(0, 1'b0, 32'h0, 32'h0,        4'h0, 32'h1,        1'b0, 1'b1, lowc);
    chk("l0_rdy_in_resp", lowc, 0);
    issue(0, 1'b1, 32'h8, 32'h77,       4'hF, 32'h77,       1'b0, 1'b1, lowc);
    issue(0, 1'b0, 32'h8, 32'h0,        4'h0, 32'h77,       1'b0, 1'b1, lowc);
    issue(0, 1'b0, 32'h9, 32'h0,        4'h0, 32'h0,        1'b1, 1'b1, lowc);
    idle(0);
    drain();

    // LATENCY=2: request held high through WAIT
    issue(2, 1'b1, 32'h8, 32'hABCD0123, 4'hF, 32'hABCD0123, 1'b0, 1'b1, lowc);
    for (int i = 0; i < 3; i++) begin
      issue(2, 1'b0, 32'h8, 32'h0, 4'h0, 32'hABCD0123, 1'b0, 1'b1, lowc);
      chk("l2_wait_rdy_low_cycles", lowc, 2);
    end
    idle(2);
    drain();

    // LATENCY=3: reset during WAIT drops the pending write
    issue(3, 1'b1, 32'h20, 32'h12345678, 4'hF, 32'h12345678, 1'b0, 1'b1, lowc);
    idle(3);
    drain();
    issue(3, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 1'b0, lowc);
    idle(3);
    @(negedge clk);
    rst[3] = 1'b1;
    #1;
    chk("midrst_rdy", {31'd0, rdy[3]}, 32'd0);
    chk("midrst_valid", {31'd0, valid[3]}, 32'd0);
    chk("midrst_rd", rd[3], 32'd0);
    chk("midrst_err", {31'd0, err[3]}, 32'd0);
    repeat (2) @(negedge clk);
    rst[3] = 1'b0;
    #1;
    chk("midrst_release_rdy", {31'd0, rdy[3]}, 32'd1);
    repeat (5) @(negedge clk);
    chk("midrst_no_resp", {31'd0, valid[3]}, 32'd0);
    issue(3, 1'b0, 32'h20, 32'h0, 4'h0, 32'h12345678, 1'b0, 1'b1, lowc);
    idle(3);
    drain();

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
